ahb2_arbiter: RTL and testbench
===============================

// Module: ahb2_arbiter
// PURPOSE
//  Parametrised AHB2 (ARM IHI 0011A) bus arbiter for NUM_MST masters on one AHB2_MST_INTF-style bus.
//  Samples hbusreq, issues a one-hot hgrant, and tracks address/data-phase ownership (hmaster, hmaster_data)
//  to steer the top-level address/data muxes. Locks fixed-length bursts, supports fixed-priority or
//  round-robin mode, and optionally handles SPLIT masking.
// PARAMETERS
//  NUM_MST   4   number of masters, 2..16
//  ARB_MODE  1   0 = fixed priority (index 0 highest); 1 = round-robin
//  DEF_MST   0   default master, granted when nobody requests; never split-masked
//  MST_W     $clog2(NUM_MST)   width of master index (derived, do not override)
// PORTS
//  hclk          in   1        bus clock
//  hreset_n      in   1        asynchronous active-low reset
//  hbusreq       in   NUM_MST  per-master bus request
//  htrans        in   2        muxed HTRANS of current address-phase owner
//  hburst        in   3        muxed HBURST of current address-phase owner
//  hready        in   1        bus HREADY
//  hresp         in   2        bus HRESP
//  hsplit        in   NUM_MST  slave split-release vector (only with AHB2_ARB_SPLIT_EN)
//  hgrant        out  NUM_MST  one-hot grant, registered
//  hmaster       out  MST_W    address-phase owner index
//  hmaster_data  out  MST_W    data-phase owner index
// BEHAVIOUR
//  - One clock, hclk; reset asynchronous, active-low (hreset_n).
//  - Reset: hgrant = 1<<DEF_MST, hmaster = hmaster_data = DEF_MST, rem = 0, rr_ptr = DEF_MST, split_mask = 0.
//  - Ownership: on a rising edge with hready=1: hmaster <= index(hgrant), hmaster_data <= hmaster.
//    hready=0 holds both.
//  - Beat counter rem (5b), updated only on edges with hready=1:
//    - NONSEQ with INCR4/WRAP4 -> 3; INCR8/WRAP8 -> 7; INCR16/WRAP16 -> 15.
//    - NONSEQ with SINGLE/INCR -> 0.
//    - SEQ and rem!=0 -> rem-1.
//    - IDLE -> 0. BUSY holds.
//    - Any hresp RETRY/SPLIT/ERROR with hready=1 -> 0 (early termination).
//  - arb_open = (rem<=1) && !(hready && htrans==NONSEQ && hburst is fixed-length).
//  - hgrant is recomputed on every edge where arb_open=1, independent of hready; otherwise held.
//    - At rem==1 the new grant becomes visible after the last beat is accepted.
//    - Ownership moves at the following hready edge: one bubble cycle per handover, by design.
//  - Eligible set E = hbusreq & ~split_mask.
//  - E==0 -> grant DEF_MST.
//  - ARB_MODE=0: lowest set index of E.
//  - ARB_MODE=1: first set index of E searching upward (wrapping) from rr_ptr+1.
//    - rr_ptr <= granted index whenever hgrant changes to a requesting master.
//    - A sole requester keeps its grant.
//  - Current owner still requesting in INCR (undefined length) burst: re-arbitrated normally
//    (may lose the bus mid-INCR; the master must rebuild with NONSEQ).
//  - hgrant is always exactly one-hot; never all-zero.
//  - Reset mid-burst: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  - AHB2_ARB_SPLIT_EN defined:
//    - hsplit port present.
//    - On edge with hready=1 and hresp==SPLIT: split_mask[hmaster_data] <= 1, unless it is DEF_MST.
//    - hsplit[i]=1 clears split_mask[i] on the next edge.
//    - Set and clear of the same bit in one cycle: clear wins.
//    - If the masked master currently holds hgrant and arb_open=1: grant moves to the next eligible
//      master, or DEF_MST.
//  - AHB2_ARB_SPLIT_EN undefined:
//    - No hsplit port; split_mask tied 0.
//    - SPLIT handled exactly like RETRY (burst terminated, re-arbitration allowed, no masking).
// TESTING
//  1. Reset, hbusreq=0: hgrant=0001, hmaster=hmaster_data=0. Hold 10 cycles: no change.
//  2. ARB_MODE=0, hbusreq=0110, all IDLE, hready=1:
//     hgrant=0010 after 1 edge, hmaster=1 after 2, hmaster_data=1 after 3.
//  3. M1 owns bus and issues INCR4 while hbusreq=0110: hgrant stays 0010 through 4 beats
//     (with 2 hready=0 stalls mid-burst); switches to 0100 after the 4th beat is accepted.
//  4. ARB_MODE=1, hbusreq=1111 held, IDLE transfers: grant sequence 0010,0100,1000,0001,0010.
//  5. M2 INCR8 terminated by RETRY at beat 3: rem->0, arb_open=1, grant re-evaluated next edge.
//  6. SPLIT_EN, M2 gets SPLIT: M2 excluded though hbusreq[2]=1 until hsplit=0100 pulse,
//     then granted at its next arbitration turn; split to M0 (DEF_MST) never masks.

Source files
------------

// File: rtl/ahb2_arbiter.sv
// AHB2 bus arbiter: one-hot registered grant, fixed-length burst locking, fixed-priority or round-robin.
// Optional SPLIT masking with the hsplit release port is enabled by defining AHB2_ARB_SPLIT_EN.
module ahb2_arbiter #(
    parameter int NUM_MST  = 4,
    parameter int ARB_MODE = 1,
    parameter int DEF_MST  = 0,
    parameter int MST_W    = $clog2(NUM_MST)
) (
    input  logic               hclk,
    input  logic               hreset_n,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    input  logic [1:0]         hresp,
`ifdef AHB2_ARB_SPLIT_EN
    input  logic [NUM_MST-1:0] hsplit,
`endif
    output logic [NUM_MST-1:0] hgrant,
    output logic [MST_W-1:0]   hmaster,
    output logic [MST_W-1:0]   hmaster_data
);

    typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_e;
    typedef enum logic [1:0] {RSP_OKAY, RSP_ERROR, RSP_RETRY, RSP_SPLIT} hresp_e;
    typedef enum logic [2:0] {
        BU_SINGLE, BU_INCR, BU_WRAP4, BU_INCR4, BU_WRAP8, BU_INCR8, BU_WRAP16, BU_INCR16
    } hburst_e;

    localparam int unsigned        N       = NUM_MST;
    localparam logic [MST_W-1:0]   DEF_IDX = MST_W'(DEF_MST);
    localparam logic [NUM_MST-1:0] DEF_GNT = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;

    logic [4:0]         rem_q, rem_d;
    logic [NUM_MST-1:0] hgrant_q, hgrant_d;
    logic [MST_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [MST_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MST_W-1:0]   hmaster_q, hmaster_d;
    logic [MST_W-1:0]   hmaster_data_q, hmaster_data_d;
    logic [NUM_MST-1:0] split_mask;
    logic [NUM_MST-1:0] elig;
    logic [MST_W-1:0]   win_idx;
    logic [MST_W-1:0]   sel;
    logic               found;
    int unsigned        cand;
    logic [4:0]         burst_beats;
    logic               fixed_burst;
    logic               arb_open;

    always_comb begin
        burst_beats = '0;
        fixed_burst = 1'b1;
        case (hburst_e'(hburst))
            BU_WRAP4,  BU_INCR4:  burst_beats = 5'd3;
            BU_WRAP8,  BU_INCR8:  burst_beats = 5'd7;
            BU_WRAP16, BU_INCR16: burst_beats = 5'd15;
            default:              fixed_burst = 1'b0;
        endcase
    end

    // Any non-OKAY response accepted with hready terminates the burst early.
    always_comb begin
        rem_d = rem_q;
        if (hready) begin
            if (hresp_e'(hresp) != RSP_OKAY) begin
                rem_d = '0;
            end else begin
                case (htrans_e'(htrans))
                    TR_NONSEQ: rem_d = burst_beats;
                    TR_SEQ:    if (rem_q != '0) rem_d = rem_q - 5'd1;
                    TR_IDLE:   rem_d = '0;
                    default:   rem_d = rem_q;
                endcase
            end
        end
    end

    assign arb_open = (rem_q <= 5'd1) &&
                      !(hready && (htrans_e'(htrans) == TR_NONSEQ) && fixed_burst);
    assign elig     = hbusreq & ~split_mask;

    always_comb begin
        win_idx = DEF_IDX;
        found   = 1'b0;
        cand    = 0;
        sel     = '0;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                sel = i[MST_W-1:0];
                if (!found && elig[sel]) begin
                    win_idx = sel;
                    found   = 1'b1;
                end
            end
        end else begin
            // Search ends on rr_ptr itself, so a sole requester keeps its grant.
            for (int unsigned k = 1; k <= N; k++) begin
                cand = (int'(rr_ptr_q) + k) % N;
                sel  = cand[MST_W-1:0];
                if (!found && elig[sel]) begin
                    win_idx = sel;
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hgrant_d       = hgrant_q;
        gnt_idx_d      = gnt_idx_q;
        rr_ptr_d       = rr_ptr_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        if (arb_open) begin
            gnt_idx_d = win_idx;
            hgrant_d  = {{(NUM_MST-1){1'b0}}, 1'b1} << win_idx;
            if ((elig != '0) && (win_idx != gnt_idx_q)) rr_ptr_d = win_idx;
        end
        if (hready) begin
            hmaster_d      = gnt_idx_q;
            hmaster_data_d = hmaster_q;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            rem_q          <= '0;
            hgrant_q       <= DEF_GNT;
            gnt_idx_q      <= DEF_IDX;
            rr_ptr_q       <= DEF_IDX;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
        end else begin
            rem_q          <= rem_d;
            hgrant_q       <= hgrant_d;
            gnt_idx_q      <= gnt_idx_d;
            rr_ptr_q       <= rr_ptr_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
        end
    end

`ifdef AHB2_ARB_SPLIT_EN
    logic [NUM_MST-1:0] split_mask_q, split_mask_d;

    // Release after set so a same-cycle hsplit clear wins.
    always_comb begin
        split_mask_d = split_mask_q;
        if (hready && (hresp_e'(hresp) == RSP_SPLIT) && (hmaster_data_q != DEF_IDX))
            split_mask_d[hmaster_data_q] = 1'b1;
        split_mask_d = split_mask_d & ~hsplit;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) split_mask_q <= '0;
        else           split_mask_q <= split_mask_d;
    end

    assign split_mask = split_mask_q;
`else
    assign split_mask = '0;
`endif

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;

endmodule

// File: tb/tb_ahb2_arbiter.sv
// Directed bench for ahb2_arbiter: a fixed-priority and a round-robin instance share one stimulus.
module tb_ahb2_arbiter;

    localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
    localparam logic [1:0] OKAY = 2'd0, RETRY = 2'd2, SPLIT = 2'd3;
    localparam logic [2:0] INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic [3:0] hbusreq;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
`ifdef AHB2_ARB_SPLIT_EN
    logic [3:0] hsplit;
`endif
    logic [3:0] fp_gnt, rr_gnt;
    logic [1:0] fp_mst, fp_mdat, rr_mst, rr_mdat;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    always #5 hclk = ~hclk;

    ahb2_arbiter #(.NUM_MST(4), .ARB_MODE(0), .DEF_MST(0)) u_fp (
        .hclk(hclk), .hreset_n(hreset_n), .hbusreq(hbusreq), .htrans(htrans),
        .hburst(hburst), .hready(hready), .hresp(hresp),
`ifdef AHB2_ARB_SPLIT_EN
        .hsplit(hsplit),
`endif
        .hgrant(fp_gnt), .hmaster(fp_mst), .hmaster_data(fp_mdat)
    );

    ahb2_arbiter #(.NUM_MST(4), .ARB_MODE(1), .DEF_MST(0)) u_rr (
        .hclk(hclk), .hreset_n(hreset_n), .hbusreq(hbusreq), .htrans(htrans),
        .hburst(hburst), .hready(hready), .hresp(hresp),
`ifdef AHB2_ARB_SPLIT_EN
        .hsplit(hsplit),
`endif
        .hgrant(rr_gnt), .hmaster(rr_mst), .hmaster_data(rr_mdat)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] req);
        hreset_n = 1'b0;
        hbusreq  = req;
        htrans   = IDLE;
        hburst   = 3'd0;
        hready   = 1'b1;
        hresp    = OKAY;
`ifdef AHB2_ARB_SPLIT_EN
        hsplit   = 4'b0000;
`endif
        @(negedge hclk);
        hreset_n = 1'b1;
    endtask

    logic [3:0] rr_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`ifdef AHB2_ARB_SPLIT_EN
    logic [3:0] split_seq [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
`else
    logic [3:0] split_seq [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
`endif

    initial begin
        hreset_n = 1'b0;

        // Reset state and idle hold
        do_reset(4'b0000);
        chk("rst_gnt", fp_gnt, 4'b0001);
        chk("rst_mst", 4'(fp_mst), 4'd0);
        chk("rst_mdat", 4'(fp_mdat), 4'd0);
        chk("rst_rr_gnt", rr_gnt, 4'b0001);
        repeat (10) tick();
        chk("idle_gnt", fp_gnt, 4'b0001);
        chk("idle_mst", 4'(fp_mst), 4'd0);
        chk("idle_mdat", 4'(fp_mdat), 4'd0);
        chk("idle_rr_gnt", rr_gnt, 4'b0001);

        // Fixed priority ownership pipeline
        hbusreq = 4'b0110;
        tick();
        chk("fp_gnt1", fp_gnt, 4'b0010);
        chk("fp_mst0", 4'(fp_mst), 4'd0);
        tick();
        chk("fp_mst1", 4'(fp_mst), 4'd1);
        chk("fp_mdat0", 4'(fp_mdat), 4'd0);
        tick();
        chk("fp_mdat1", 4'(fp_mdat), 4'd1);
        chk("fp_gnt_keep", fp_gnt, 4'b0010);

        // Round-robin rotation
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_seq", rr_gnt, rr_seq[i]);
        end

        // INCR4 lock with stalls, handover after the fourth beat
        do_reset(4'b0010);
        tick();
        chk("b4_gnt", rr_gnt, 4'b0010);
        tick();
        chk("b4_mst", 4'(rr_mst), 4'd1);
        htrans = NONSEQ; hburst = INCR4; hbusreq = 4'b0110;
        tick();
        chk("b4_beat1", rr_gnt, 4'b0010);
        htrans = SEQ; hready = 1'b0;
        tick();
        chk("b4_stall1", rr_gnt, 4'b0010);
        hready = 1'b1;
        tick();
        chk("b4_beat2", rr_gnt, 4'b0010);
        hready = 1'b0;
        tick();
        chk("b4_stall2", rr_gnt, 4'b0010);
        hready = 1'b1;
        tick();
        chk("b4_beat3", rr_gnt, 4'b0010);
        chk("b4_mst_lock", 4'(rr_mst), 4'd1);
        tick();
        chk("b4_handover", rr_gnt, 4'b0100);
        htrans = IDLE; hbusreq = 4'b0100; hready = 1'b0;
        tick();
        chk("stall_gnt", rr_gnt, 4'b0100);
        chk("stall_mst_hold", 4'(rr_mst), 4'd1);
        hready = 1'b1;
        tick();
        chk("own_mst2", 4'(rr_mst), 4'd2);

        // INCR8 terminated by RETRY at beat 3
        htrans = NONSEQ; hburst = INCR8; hbusreq = 4'b0101;
        tick();
        chk("b8_beat1", rr_gnt, 4'b0100);
        htrans = SEQ;
        tick();
        chk("b8_beat2", rr_gnt, 4'b0100);
        tick();
        chk("b8_beat3", rr_gnt, 4'b0100);
        hresp = RETRY; hready = 1'b0;
        tick();
        chk("retry_c1", rr_gnt, 4'b0100);
        hready = 1'b1; htrans = IDLE;
        tick();
        chk("retry_c2", rr_gnt, 4'b0100);
        hresp = OKAY;
        tick();
        chk("retry_regrant", rr_gnt, 4'b0001);

        // Asynchronous reset in the middle of a locked burst
        htrans = NONSEQ; hburst = INCR16; hbusreq = 4'b0010;
        tick();
        #2;
        hreset_n = 1'b0;
        #1;
        chk("arst_gnt", rr_gnt, 4'b0001);
        chk("arst_mst", 4'(rr_mst), 4'd0);
        chk("arst_mdat", 4'(rr_mdat), 4'd0);

        // SPLIT from M2: masked only when split support is built in
        do_reset(4'b0100);
        tick();
        chk("sp_gnt", rr_gnt, 4'b0100);
        tick();
        tick();
        chk("sp_mdat", 4'(rr_mdat), 4'd2);
        hresp = SPLIT; hbusreq = 4'b0101;
        tick();
        chk("sp_gnt0", rr_gnt, 4'b0001);
        hresp = OKAY;
        for (int i = 0; i < 4; i++) begin
`ifdef AHB2_ARB_SPLIT_EN
            hsplit = (i == 2) ? 4'b0100 : 4'b0000;
`endif
            tick();
            chk("sp_seq", rr_gnt, split_seq[i]);
        end

        // SPLIT against the default master never masks it
        do_reset(4'b0011);
        hresp = SPLIT;
        tick();
        hresp = OKAY;
        tick();
        chk("def_split1", fp_gnt, 4'b0001);
        tick();
        chk("def_split2", fp_gnt, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
